// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// kbd_pkg : shared types and scan constants for the PS/2 key event path
// Rev 1.0
// ============================================================================
package kbd_pkg;

    localparam logic [7:0] c_scan_bat = 8'hAA;
    localparam logic [7:0] c_scan_ext = 8'hE0;
    localparam logic [7:0] c_scan_rel = 8'hF0;
    localparam int         c_evt_w    = 10;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } kbd_event_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_REL     = 2'd2,
        ST_EXT_REL = 2'd3
    } kbd_state_e;

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// event_fifo : show-ahead FIFO with registered head/valid and synchronous flush
// Rev 1.0
// ============================================================================
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_do_pop;
    logic             w_do_push;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [AW:0]      w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign full         = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop     = pop && r_valid;
    assign w_do_push    = push && (!full || w_do_pop);
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    assign w_count_next = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

    // Head is kept in its own register so the outputs never pass through the RAM mux.
    always_comb begin
        w_head_next = r_head;
        if (w_do_pop) begin
            if (r_count == (AW+1)'(1))
                w_head_next = w_do_push ? push_data : '0;
            else
                w_head_next = r_mem[w_rd_ptr_inc];
        end else if ((r_count == '0) && w_do_push) begin
            w_head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_do_pop)
                r_rd_ptr <= w_rd_ptr_inc;
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= w_count_next;
            r_head  <= w_head_next;
            r_valid <= (w_count_next != '0);
        end
    end

    assign head  = r_head;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// key_event_ctrl : PS/2 strobe synchroniser, E0/F0 prefix sequencer, event FIFO
// Rev 1.0
// ============================================================================
module key_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] rx_data,
    input  logic        rx_latch,
    input  logic        rx_reset_required,
    input  logic        rx_release,
    input  logic        rx_extended,
    output logic [7:0]  evt_code,
    output logic        evt_release,
    output logic        evt_extended,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        kbd_ready,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    // Strobe index: 0 latch, 1 extended, 2 release, 3 reset_required
    logic [3:0] w_strobe;
    logic [3:0] w_pulse;
    assign w_strobe = {rx_reset_required, rx_release, rx_extended, rx_latch};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        logic r_s1, r_s2, r_s3, r_pulse;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_s3    <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_s1    <= w_strobe[gi];
                r_s2    <= r_s1;
                r_s3    <= r_s2;
                r_pulse <= r_s2 & ~r_s3;
            end
        end
        assign w_pulse[gi] = r_pulse;
    end

    logic w_bat, w_rel, w_ext, w_lat;
    assign w_bat = w_pulse[3];
    assign w_rel = w_pulse[2] & ~w_pulse[3];
    assign w_ext = w_pulse[1] & ~(|w_pulse[3:2]);
    assign w_lat = w_pulse[0] & ~(|w_pulse[3:1]);

    kbd_state_e      r_state, w_state_next;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_tmo_hit;
    logic            w_tmo;
    logic            w_push;
    kbd_event_t      w_push_evt;
    logic            r_push;
    kbd_event_t      r_push_evt;
    logic            w_full;
    logic            w_drop;
    logic [c_evt_w-1:0] w_head_bits;
    kbd_event_t      w_head;
    logic            w_unused_rx;

    assign w_unused_rx = ^{rx_data[10:9], rx_data[0]};
    assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_evt   = '{code: rx_data[8:1], rel: 1'b0, ext: 1'b0};
        w_tmo        = 1'b0;
        if (w_bat) begin
            w_state_next = ST_IDLE;
        end else if (w_rel || w_ext || w_lat) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ext)      w_state_next = ST_EXT;
                    else if (w_rel) w_state_next = ST_REL;
                    else            w_push = 1'b1;
                end
                ST_EXT: begin
                    if (w_rel) begin
                        w_state_next = ST_EXT_REL;
                    end else if (w_lat) begin
                        w_push         = 1'b1;
                        w_push_evt.ext = 1'b1;
                        w_state_next   = ST_IDLE;
                    end
                end
                ST_REL: begin
                    if (w_ext) begin
                        w_state_next = ST_EXT_REL;
                    end else if (w_lat) begin
                        w_push         = 1'b1;
                        w_push_evt.rel = 1'b1;
                        w_state_next   = ST_IDLE;
                    end
                end
                default: begin
                    if (w_lat) begin
                        w_push         = 1'b1;
                        w_push_evt.rel = 1'b1;
                        w_push_evt.ext = 1'b1;
                        w_state_next   = ST_IDLE;
                    end
                end
            endcase
        end else if ((r_state != ST_IDLE) && w_tmo_hit) begin
            w_state_next = ST_IDLE;
            w_tmo        = 1'b1;
        end
    end

    // A push still pending when a flush arrives is discarded with the flush.
    assign w_drop = r_push && w_full && !(evt_valid && evt_ready) && !w_bat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tmo_cnt  <= '0;
            r_push     <= 1'b0;
            r_push_evt <= '0;
            kbd_ready  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((|w_pulse) || (w_state_next != r_state) || (r_state == ST_IDLE))
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_push <= w_push;
            if (w_push)
                r_push_evt <= w_push_evt;
            if (w_bat)
                kbd_ready <= 1'b1;
            if (w_tmo || w_drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    event_fifo #(
        .WIDTH (c_evt_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_bat),
        .push      (r_push),
        .push_data (r_push_evt),
        .pop       (evt_ready),
        .head      (w_head_bits),
        .valid     (evt_valid),
        .full      (w_full)
    );

    assign w_head       = kbd_event_t'(w_head_bits);
    assign evt_code     = w_head.code;
    assign evt_release  = w_head.rel;
    assign evt_extended = w_head.ext;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// tb_key_event_ctrl : directed self-checking bench for key_event_ctrl
// Rev 1.0
// ============================================================================
module tb_key_event_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] rx_data = '0;
    logic [3:0]  stb = '0;   // 0 latch, 1 extended, 2 release, 3 reset_required
    logic        evt_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [7:0]  evt_code;
    logic        evt_release, evt_extended, evt_valid, kbd_ready, overflow;

    int n_cmp = 0;
    int n_err = 0;

    key_event_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_latch          (stb[0]),
        .rx_reset_required (stb[3]),
        .rx_release        (stb[2]),
        .rx_extended       (stb[1]),
        .evt_code          (evt_code),
        .evt_release       (evt_release),
        .evt_extended      (evt_extended),
        .evt_valid         (evt_valid),
        .evt_ready         (evt_ready),
        .kbd_ready         (kbd_ready),
        .overflow          (overflow),
        .clr_overflow      (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [7:0] code,
                             input logic rel, input logic ext);
        check({tag, "_valid"}, {7'd0, evt_valid}, 8'd1);
        check({tag, "_code"}, evt_code, code);
        check({tag, "_rel"}, {7'd0, evt_release}, {7'd0, rel});
        check({tag, "_ext"}, {7'd0, evt_extended}, {7'd0, ext});
    endtask

    // Strobe held 4 clk, then 2 clk of quiet: the event is visible on return.
    task automatic send(input int which, input logic [7:0] code);
        rx_data = {2'b11, code, 1'b0};
        stb[which] = 1'b1;
        repeat (4) @(negedge clk);
        stb[which] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {7'd0, evt_valid}, 8'd0);
        check("rst_code", evt_code, 8'h00);
        check("rst_rel", {7'd0, evt_release}, 8'd0);
        check("rst_ext", {7'd0, evt_extended}, 8'd0);
        check("rst_kbd_ready", {7'd0, kbd_ready}, 8'd0);
        check("rst_overflow", {7'd0, overflow}, 8'd0);

        // BAT: kbd_ready within 4 clk, nothing queued
        stb[3] = 1'b1;
        repeat (4) @(negedge clk);
        check("bat_kbd_ready", {7'd0, kbd_ready}, 8'd1);
        check("bat_valid", {7'd0, evt_valid}, 8'd0);
        stb[3] = 1'b0;
        repeat (3) @(negedge clk);

        // Plain make: valid exactly 5 clk after the strobe edge
        rx_data = {2'b11, 8'h1C, 1'b0};
        stb[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("lat_valid_4clk", {7'd0, evt_valid}, 8'd0);
        @(negedge clk);
        check_evt("make_1c", 8'h1C, 1'b0, 1'b0);
        stb[0] = 1'b0;
        repeat (2) @(negedge clk);
        pop_one();
        check("make_1c_popped", {7'd0, evt_valid}, 8'd0);

        // E0 F0 74 -> single extended release
        send(1, 8'hE0);
        send(2, 8'hF0);
        check("pfx_no_evt", {7'd0, evt_valid}, 8'd0);
        send(0, 8'h74);
        check_evt("ext_rel_74", 8'h74, 1'b1, 1'b1);
        pop_one();
        check("ext_rel_popped", {7'd0, evt_valid}, 8'd0);

        // Nine makes into an 8-deep FIFO
        for (int i = 0; i < 9; i++)
            send(0, 8'h10 + 8'(i));
        check("full_overflow", {7'd0, overflow}, 8'd1);
        check_evt("full_head", 8'h10, 1'b0, 1'b0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("clr_overflow", {7'd0, overflow}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            check_evt("drain", 8'h10 + 8'(i), 1'b0, 1'b0);
            pop_one();
        end
        check("drain_empty", {7'd0, evt_valid}, 8'd0);

        // F0 prefix abandoned -> timeout
        send(2, 8'hF0);
        check("tmo_not_yet", {7'd0, overflow}, 8'd0);
        repeat (TMO) @(negedge clk);
        check("tmo_overflow", {7'd0, overflow}, 8'd1);
        check("tmo_valid", {7'd0, evt_valid}, 8'd0);
        send(0, 8'h1C);
        check_evt("post_tmo", 8'h1C, 1'b0, 1'b0);
        pop_one();
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;

        // Reset mid-FIFO and mid-prefix
        send(0, 8'h33);
        check_evt("pre_rst", 8'h33, 1'b0, 1'b0);
        send(1, 8'hE0);
        rst = 1'b1;
        #1;
        check("arst_valid", {7'd0, evt_valid}, 8'd0);
        check("arst_code", evt_code, 8'h00);
        check("arst_kbd_ready", {7'd0, kbd_ready}, 8'd0);
        check("arst_overflow", {7'd0, overflow}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h29);
        check_evt("post_rst", 8'h29, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
